// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one 32-bit ALU between two requesters.
// Ports: clk, rst_n (sync, active low); req0_*/req1_* valid/ready request
//   channels (a, b, op, tag); rsp_* valid/ready response (id, tag, out,
//   zero, of); busy (not idle); op_count (completed responses, wraps).
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [1:0]        req0_op,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [1:0]        req1_op,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [DATA_W-1:0] rsp_out,
    output logic              rsp_zero,
    output logic              rsp_of,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    localparam int MSB = DATA_W - 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic               prio;
    logic               gnt0;
    logic               gnt1;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [1:0]         op_q;
    logic [TAG_W-1:0]   tag_q;
    logic               id_q;
    logic [DATA_W-1:0]  res_q;
    logic               zero_q;
    logic               of_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  alu_out;
    logic               alu_of;

    // Grant only in IDLE; prio breaks ties and flips after each response.
    always_comb begin
        state_nx = state;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        unique case (state)
            IDLE: begin
                gnt0 = req0_valid & (~req1_valid | ~prio);
                gnt1 = req1_valid & (~req0_valid | prio);
                if (gnt0 | gnt1)
                    state_nx = EXEC;
            end
            EXEC: state_nx = RESP;
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Overflow from operand/result sign bits; logic ops never overflow.
    always_comb begin
        alu_out = '0;
        alu_of  = 1'b0;
        unique case (op_q)
            2'b00: begin
                alu_out = a_q + b_q;
                alu_of  = (a_q[MSB] == b_q[MSB])
                        && (alu_out[MSB] != a_q[MSB]);
            end
            2'b01: begin
                alu_out = a_q - b_q;
                alu_of  = (a_q[MSB] != b_q[MSB])
                        && (alu_out[MSB] != a_q[MSB]);
            end
            2'b10: alu_out = a_q & b_q;
            2'b11: alu_out = a_q | b_q;
            default: alu_out = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            prio   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            tag_q  <= '0;
            id_q   <= 1'b0;
            res_q  <= '0;
            zero_q <= 1'b0;
            of_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            state <= state_nx;
            if (gnt0 | gnt1) begin
                a_q   <= gnt1 ? req1_a   : req0_a;
                b_q   <= gnt1 ? req1_b   : req0_b;
                op_q  <= gnt1 ? req1_op  : req0_op;
                tag_q <= gnt1 ? req1_tag : req0_tag;
                id_q  <= gnt1;
            end
            if (state == EXEC) begin
                res_q  <= alu_out;
                zero_q <= (alu_out == '0);
                of_q   <= alu_of;
            end
            if (state == RESP && rsp_ready) begin
                cnt_q <= cnt_q + CNT_W'(1);
                prio  <= ~id_q;
            end
        end
    end

    // Ready is held low while reset is asserted so nothing looks accepted.
    assign req0_ready = gnt0 & rst_n;
    assign req1_ready = gnt1 & rst_n;
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);
    assign rsp_id     = id_q;
    assign rsp_tag    = tag_q;
    assign rsp_out    = res_q;
    assign rsp_zero   = zero_q;
    assign rsp_of     = of_q;
    assign op_count   = cnt_q;

endmodule
